// File: rtl/ponylink_test_pkg.sv
// -----------------------------------------------------------------------------
// ponylink_test_pkg
// Shared definitions for the PonyLink link-test generator/checker pair:
//   - xorshift32 step function (x ^= x<<13; x ^= x>>7; x ^= x<<17)
//   - seed sanitiser (an all-zero xorshift state never leaves zero)
//   - checker state enum
//   - default PRNG seed
// -----------------------------------------------------------------------------
package ponylink_test_pkg;

    localparam logic [31:0] PONYLINK_TEST_SEED_DEFAULT = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } chk_state_e;

    // One xorshift32 step; both link ends must use this exact sequence.
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Zero is a fixed point of xorshift, so it is replaced by 1.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        logic [31:0] r;
        if (s == 32'd0) begin
            r = 32'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Mask covering tdata (low bits) and tuser (high bits) of the PRNG word.
    function automatic logic [31:0] field_mask(input int dw, input int uw);
        logic [31:0] m;
        m = (32'hFFFF_FFFF >> (32 - dw)) | ~(32'hFFFF_FFFF >> uw);
        return m;
    endfunction

endpackage

// File: rtl/ponylink_xorshift32.sv
// -----------------------------------------------------------------------------
// ponylink_xorshift32
// 32-bit xorshift PRNG register shared by the link-test generator and checker.
// Ports:
//   clk    in   clock
//   resetn in   asynchronous active-low reset (state <- sanitised SEED)
//   load   in   synchronous reload of the sanitised SEED, wins over step
//   step   in   advance the sequence by one value
//   value  out  current PRNG state (value used before the next step)
// -----------------------------------------------------------------------------
module ponylink_xorshift32
    import ponylink_test_pkg::*;
#(
    parameter logic [31:0] SEED = PONYLINK_TEST_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    localparam logic [31:0] START_VALUE = seed_fix(SEED);

    logic [31:0] state_r;

    // PRNG state register: reset/load to the start value, otherwise step on demand.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= START_VALUE;
        end else if (load) begin
            state_r <= START_VALUE;
        end else if (step) begin
            state_r <= xorshift32(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign value = state_r;

endmodule

// File: rtl/ponylink_stream_check.sv
// -----------------------------------------------------------------------------
// ponylink_stream_check
// AXI-stream sink that checks every accepted beat against a locally
// regenerated xorshift32 sequence and exports integrity statistics.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   enable                run the checker; low holds state and drops in_tready
//   clear                 synchronous restart of counters/PRNG/index/state
//   in_tdata/tuser/tvalid/tlast, in_tready   checked stream
//   word_count            accepted beats (wrapping)
//   pkt_count             accepted beats carrying tlast (wrapping)
//   err_count             mismatching beats (saturating)
//   error                 sticky mismatch flag
//   in_sync               high while in RUN
// -----------------------------------------------------------------------------
module ponylink_stream_check
    import ponylink_test_pkg::*;
#(
    parameter int          TDATA_WIDTH   = 8,
    parameter int          TUSER_WIDTH   = 1,
    parameter int          PKT_LEN       = 16,
    parameter logic [31:0] SEED          = PONYLINK_TEST_SEED_DEFAULT,
    parameter logic [15:0] READY_PATTERN = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [TDATA_WIDTH-1:0] in_tdata,
    input  logic [TUSER_WIDTH-1:0] in_tuser,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    output logic                   in_tready,
    output logic [31:0]            word_count,
    output logic [15:0]            pkt_count,
    output logic [15:0]            err_count,
    output logic                   error,
    output logic                   in_sync
);

    localparam logic [15:0] LAST_IDX   = 16'(PKT_LEN - 1);
    localparam logic [31:0] FIELD_MASK = field_mask(TDATA_WIDTH, TUSER_WIDTH);

    chk_state_e  state_r;
    chk_state_e  mode_r;      // RUN or RESYNC, restored when leaving IDLE
    logic [15:0] idx_r;
    logic [3:0]  ptr_r;
    logic [31:0] word_r;
    logic [15:0] pkt_r;
    logic [15:0] err_r;
    logic        error_r;
    logic        in_sync_r;

    logic [31:0] prng_s;
    logic [31:0] obs_s;
    logic [31:0] diff_s;
    logic        accept_s;
    logic        exp_last_s;
    logic        last_bad_s;
    logic        mismatch_s;
    logic        cmp_bad_s;
    logic [15:0] idx_next_s;

    ponylink_xorshift32 #(
        .SEED (SEED)
    ) u_prng (
        .clk    (clk),
        .resetn (resetn),
        .load   (clear),
        .step   (accept_s && !clear),
        .value  (prng_s)
    );

    // Ready follows enable combinationally so a falling enable blocks the same cycle.
    assign in_tready = (state_r != ST_IDLE) && enable && READY_PATTERN[ptr_r];
    assign accept_s  = in_tvalid && in_tready;
    assign cmp_bad_s = (state_r == ST_RUN) && mismatch_s;

    // Beat comparison: the observed fields are packed into PRNG bit positions
    // so one masked XOR covers tdata (low bits) and tuser (high bits).
    always_comb begin
        obs_s = 32'd0;
        obs_s[TDATA_WIDTH-1:0] = in_tdata;
        obs_s[31 -: TUSER_WIDTH] = in_tuser;
        diff_s = obs_s ^ prng_s;
        exp_last_s = (idx_r == LAST_IDX);
        last_bad_s = (in_tlast != exp_last_s);
        mismatch_s = (|(diff_s & FIELD_MASK)) || last_bad_s;
        if (exp_last_s) begin
            idx_next_s = 16'd0;
        end else begin
            idx_next_s = idx_r + 16'd1;
        end
    end

    // Throttle pattern pointer: free-running, restarted only by reset or clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= 4'd0;
        end else if (clear) begin
            ptr_r <= 4'd0;
        end else begin
            ptr_r <= ptr_r + 4'd1;
        end
    end

    // Checker FSM with beat index and registered in_sync.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            mode_r    <= ST_RUN;
            idx_r     <= 16'd0;
            in_sync_r <= 1'b0;
        end else if (clear) begin
            state_r   <= ST_IDLE;
            mode_r    <= ST_RUN;
            idx_r     <= 16'd0;
            in_sync_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r   <= mode_r;
                        in_sync_r <= (mode_r == ST_RUN);
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r   <= ST_IDLE;
                        in_sync_r <= 1'b0;
                    end else if (accept_s) begin
                        idx_r <= idx_next_s;
                        // A misplaced tlast means beats were lost or duplicated.
                        if (last_bad_s) begin
                            state_r   <= ST_RESYNC;
                            mode_r    <= ST_RESYNC;
                            in_sync_r <= 1'b0;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (!enable) begin
                        state_r   <= ST_IDLE;
                        in_sync_r <= 1'b0;
                    end else if (accept_s) begin
                        // Realign the index on the sender's packet boundary;
                        // the PRNG keeps running so a lost beat stays visible.
                        if (in_tlast) begin
                            idx_r     <= 16'd0;
                            state_r   <= ST_RUN;
                            mode_r    <= ST_RUN;
                            in_sync_r <= 1'b1;
                        end else begin
                            idx_r <= idx_next_s;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mode_r    <= ST_RUN;
                    idx_r     <= 16'd0;
                    in_sync_r <= 1'b0;
                end
            endcase
        end
    end

    // Beat, packet and error statistics; a beat coinciding with clear is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_r  <= 32'd0;
            pkt_r   <= 16'd0;
            err_r   <= 16'd0;
            error_r <= 1'b0;
        end else if (clear) begin
            word_r  <= 32'd0;
            pkt_r   <= 16'd0;
            err_r   <= 16'd0;
            error_r <= 1'b0;
        end else if (accept_s) begin
            word_r <= word_r + 32'd1;
            if (in_tlast) begin
                pkt_r <= pkt_r + 16'd1;
            end
            if (cmp_bad_s) begin
                error_r <= 1'b1;
                if (err_r != 16'hFFFF) begin
                    err_r <= err_r + 16'd1;
                end
            end
        end
    end

    assign word_count = word_r;
    assign pkt_count  = pkt_r;
    assign err_count  = err_r;
    assign error      = error_r;
    assign in_sync    = in_sync_r;

endmodule

// File: tb/tb_ponylink_stream_check.sv
// -----------------------------------------------------------------------------
// tb_ponylink_stream_check
// Self-checking bench for ponylink_stream_check. The main instance runs with a
// full ready pattern; a second instance uses 16'h5555 and an illegal zero seed.
// A reference model predicts the status after each clock edge and queues it;
// a monitor process pops and compares once the DUT has updated.
// -----------------------------------------------------------------------------
module tb_ponylink_stream_check;

    localparam int PL       = 16;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_RESYNC = 2;
    localparam logic [15:0] T_PATTERN = 16'h5555;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;

    // main instance
    logic        enable = 1'b0;
    logic        clear  = 1'b0;
    logic [7:0]  tdata  = 8'd0;
    logic [0:0]  tuser  = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic        tready;
    logic [31:0] word_count;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        error;
    logic        in_sync;

    // throttled instance
    logic        t_enable = 1'b0;
    logic        t_clear  = 1'b0;
    logic [7:0]  t_data   = 8'd0;
    logic [0:0]  t_user   = 1'b0;
    logic        t_valid  = 1'b0;
    logic        t_last   = 1'b0;
    logic        t_ready;
    logic [31:0] t_word;
    logic [15:0] t_pkt;
    logic [15:0] t_err;
    logic        t_error;
    logic        t_sync;

    always #5 clk = ~clk;

    ponylink_stream_check #(
        .TDATA_WIDTH(8), .TUSER_WIDTH(1), .PKT_LEN(PL),
        .SEED(32'h0000_0001), .READY_PATTERN(16'hFFFF)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
        .in_tdata(tdata), .in_tuser(tuser), .in_tvalid(tvalid), .in_tlast(tlast),
        .in_tready(tready), .word_count(word_count), .pkt_count(pkt_count),
        .err_count(err_count), .error(error), .in_sync(in_sync)
    );

    ponylink_stream_check #(
        .TDATA_WIDTH(8), .TUSER_WIDTH(1), .PKT_LEN(PL),
        .SEED(32'h0000_0000), .READY_PATTERN(T_PATTERN)
    ) dut_thr (
        .clk(clk), .resetn(resetn), .enable(t_enable), .clear(t_clear),
        .in_tdata(t_data), .in_tuser(t_user), .in_tvalid(t_valid), .in_tlast(t_last),
        .in_tready(t_ready), .word_count(t_word), .pkt_count(t_pkt),
        .err_count(t_err), .error(t_error), .in_sync(t_sync)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] pkt;
        logic [15:0] err;
        logic        err_flag;
        logic        sync;
        logic        ready;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model of the checker
    logic [31:0] m_x;
    int          m_idx;
    int          m_state;
    int          m_mode;
    logic [31:0] m_word;
    logic [15:0] m_pkt;
    logic [15:0] m_err;
    logic        m_error;

    // upstream stream source
    logic [31:0] src_x;
    int          src_idx;

    function automatic logic [31:0] ref_next(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = v ^ {v[18:0], 13'd0};
        b = a ^ {7'd0, a[31:7]};
        c = b ^ {b[14:0], 17'd0};
        return c;
    endfunction

    function automatic logic model_ready();
        return (m_state != S_IDLE) && enable;
    endfunction

    task automatic model_reset();
        m_x = 32'd1; m_idx = 0; m_state = S_IDLE; m_mode = S_RUN;
        m_word = 32'd0; m_pkt = 16'd0; m_err = 16'd0; m_error = 1'b0;
    endtask

    task automatic src_reset();
        src_x = 32'd1; src_idx = 0;
    endtask

    task automatic src_advance();
        src_x = ref_next(src_x);
        src_idx = (src_idx == PL - 1) ? 0 : src_idx + 1;
    endtask

    // One clock cycle on the main instance: predict, queue, advance.
    task automatic tick();
        exp_t e;
        logic acc;
        logic exp_last;
        logic bad;
        acc = tvalid && model_ready();
        e.ready = model_ready();
        if (clear) begin
            model_reset();
        end else if (m_state == S_IDLE) begin
            if (enable) m_state = m_mode;
        end else if (!enable) begin
            m_state = S_IDLE;
        end else if (acc) begin
            exp_last = (m_idx == PL - 1);
            m_word = m_word + 32'd1;
            if (tlast) m_pkt = m_pkt + 16'd1;
            if (m_state == S_RUN) begin
                bad = (tdata != m_x[7:0]) || (tuser[0] != m_x[31]) || (tlast != exp_last);
                if (bad) begin
                    m_error = 1'b1;
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                end
                if (tlast != exp_last) begin
                    m_state = S_RESYNC; m_mode = S_RESYNC;
                end
                m_idx = exp_last ? 0 : m_idx + 1;
            end else if (tlast) begin
                m_idx = 0; m_state = S_RUN; m_mode = S_RUN;
            end else begin
                m_idx = exp_last ? 0 : m_idx + 1;
            end
            m_x = ref_next(m_x);
        end
        e.word = m_word; e.pkt = m_pkt; e.err = m_err;
        e.err_flag = m_error; e.sync = (m_state == S_RUN);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: ready before the edge, status after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                checks++;
                if (tready !== sb_q[0].ready) begin
                    errors++;
                    $display("FAIL sb_tready: got %b expected %b at %0t", tready, sb_q[0].ready, $time);
                end
            end
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({word_count, pkt_count, err_count, error, in_sync} !==
                    {e.word, e.pkt, e.err, e.err_flag, e.sync}) begin
                    errors++;
                    $display("FAIL sb_status: got word=%0d pkt=%0d err=%0d error=%b sync=%b expected word=%0d pkt=%0d err=%0d error=%b sync=%b at %0t",
                             word_count, pkt_count, err_count, error, in_sync,
                             e.word, e.pkt, e.err, e.err_flag, e.sync, $time);
                end
            end
        end
    end

    // Present the next source beat and hold it until the model accepts it.
    task automatic send_beat(input logic flip);
        logic rdy;
        int   guard;
        tdata  = src_x[7:0] ^ {7'd0, flip};
        tuser  = src_x[31];
        tlast  = (src_idx == PL - 1);
        tvalid = 1'b1;
        guard  = 0;
        rdy    = model_ready();
        while (!rdy && guard < 8) begin
            tick();
            guard++;
            rdy = model_ready();
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: got no ready in %0d cycles expected ready", guard);
        end else begin
            tick();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        src_advance();
    endtask

    task automatic do_clear();
        clear = 1'b1; tvalid = 1'b0;
        tick();
        clear = 1'b0;
        src_reset();
    endtask

    task automatic test_reset();
        checks++;
        if ({word_count, pkt_count, err_count, error, in_sync, tready} !== 70'd0) begin
            errors++;
            $display("FAIL reset_held: got word=%0d pkt=%0d err=%0d error=%b sync=%b ready=%b expected all 0",
                     word_count, pkt_count, err_count, error, in_sync, tready);
        end
        resetn = 1'b1;
        model_reset();
        src_reset();
        enable = 1'b1;
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b expected 0", tready);
        end
    endtask

    task automatic test_correct_stream();
        for (int i = 0; i < 4 * PL; i++) send_beat(1'b0);
        checks++;
        if (word_count !== 32'd64 || pkt_count !== 16'd4 || err_count !== 16'd0 || error !== 1'b0 || in_sync !== 1'b1) begin
            errors++;
            $display("FAIL correct_stream: got word=%0d pkt=%0d err=%0d error=%b sync=%b expected 64 4 0 0 1",
                     word_count, pkt_count, err_count, error, in_sync);
        end
    endtask

    task automatic test_corrupt_data();
        for (int i = 0; i < PL; i++) begin
            send_beat(i == 5);
            if (i == 5) begin
                checks++;
                if (err_count !== 16'd1 || error !== 1'b1 || in_sync !== 1'b1) begin
                    errors++;
                    $display("FAIL corrupt_beat5: got err=%0d error=%b sync=%b expected 1 1 1", err_count, error, in_sync);
                end
            end
        end
        checks++;
        if (err_count !== 16'd1 || word_count !== 32'd80) begin
            errors++;
            $display("FAIL corrupt_end: got err=%0d word=%0d expected 1 80", err_count, word_count);
        end
    endtask

    task automatic test_clear_with_beat();
        tdata = src_x[7:0]; tuser = src_x[31]; tlast = 1'b0; tvalid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0; tvalid = 1'b0;
        checks++;
        if ({word_count, pkt_count, err_count, error, in_sync, tready} !== 70'd0) begin
            errors++;
            $display("FAIL clear_with_beat: got word=%0d pkt=%0d err=%0d error=%b sync=%b ready=%b expected all 0",
                     word_count, pkt_count, err_count, error, in_sync, tready);
        end
        src_reset();
        send_beat(1'b0);
        checks++;
        if (word_count !== 32'd1 || err_count !== 16'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL clear_seed_restart: got word=%0d err=%0d error=%b expected 1 0 0", word_count, err_count, error);
        end
    endtask

    task automatic test_lost_beat();
        do_clear();
        for (int i = 0; i < PL; i++) begin
            if (i == 7) src_advance();
            else send_beat(1'b0);
        end
        checks++;
        if (in_sync !== 1'b0 || err_count < 16'd1 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL lost_resync: got sync=%b err=%0d pkt=%0d expected 0 >=1 1", in_sync, err_count, pkt_count);
        end
        for (int i = 0; i < PL; i++) send_beat(1'b0);
        checks++;
        if (in_sync !== 1'b1 || pkt_count !== 16'd2 || word_count !== 32'd31) begin
            errors++;
            $display("FAIL lost_recover: got sync=%b pkt=%0d word=%0d expected 1 2 31", in_sync, pkt_count, word_count);
        end
    endtask

    task automatic test_enable_pause();
        do_clear();
        for (int i = 0; i < 6; i++) send_beat(1'b0);
        enable = 1'b0;
        tdata = src_x[7:0]; tuser = src_x[31]; tlast = 1'b0; tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (tready !== 1'b0) begin
                errors++;
                $display("FAIL pause_ready: got %b expected 0 in paused cycle %0d", tready, i);
            end
            tick();
        end
        tvalid = 1'b0;
        checks++;
        if (word_count !== 32'd6) begin
            errors++;
            $display("FAIL pause_hold: got word=%0d expected 6", word_count);
        end
        enable = 1'b1;
        for (int i = 6; i < PL; i++) send_beat(1'b0);
        checks++;
        if (word_count !== 32'd16 || pkt_count !== 16'd1 || err_count !== 16'd0 || in_sync !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got word=%0d pkt=%0d err=%0d sync=%b expected 16 1 0 1",
                     word_count, pkt_count, err_count, in_sync);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        send_beat(1'b1);
        for (int i = 0; i < 4; i++) send_beat(1'b0);
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({word_count, pkt_count, err_count, error, in_sync, tready} !== 70'd0) begin
            errors++;
            $display("FAIL async_reset: got word=%0d pkt=%0d err=%0d error=%b sync=%b ready=%b expected all 0",
                     word_count, pkt_count, err_count, error, in_sync, tready);
        end
        enable = 1'b0;
        #2;
        resetn = 1'b1;
        model_reset();
        src_reset();
        @(posedge clk);
        #2;
    endtask

    task automatic test_throttle();
        logic [31:0] tx;
        int          tidx;
        int          p;
        int          cyc;
        int          accepted;
        logic        run;
        logic        exp_r;
        t_clear = 1'b1; t_enable = 1'b1;
        @(posedge clk);
        #2;
        t_clear = 1'b0;
        tx = 32'd1; tidx = 0; p = 0; cyc = 0; accepted = 0; run = 1'b0;
        t_valid = 1'b1;
        while (accepted < 32 && cyc < 200) begin
            t_data = tx[7:0]; t_user = tx[31]; t_last = (tidx == PL - 1);
            exp_r = run && T_PATTERN[p];
            #1;
            checks++;
            if (t_ready !== exp_r) begin
                errors++;
                $display("FAIL throttle_ready: got %b expected %b at cycle %0d", t_ready, exp_r, cyc);
            end
            @(posedge clk);
            if (exp_r) begin
                accepted++;
                tx = ref_next(tx);
                tidx = (tidx == PL - 1) ? 0 : tidx + 1;
            end
            run = 1'b1;
            p = (p + 1) % 16;
            cyc++;
            #2;
        end
        t_valid = 1'b0; t_enable = 1'b0;
        checks++;
        if (cyc !== 65 || t_word !== 32'd32 || t_pkt !== 16'd2 || t_err !== 16'd0 || t_error !== 1'b0) begin
            errors++;
            $display("FAIL throttle_totals: got cycles=%0d word=%0d pkt=%0d err=%0d error=%b expected 65 32 2 0 0",
                     cyc, t_word, t_pkt, t_err, t_error);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        src_reset();
        @(posedge clk);
        #2;
        test_reset();
        test_correct_stream();
        test_corrupt_data();
        test_clear_with_beat();
        test_lost_beat();
        test_enable_pause();
        test_async_reset();
        test_throttle();
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
